prco_alu_pipe: RTL
==================

Name: prco_alu_pipe

Overview:
- Parametrised next-generation execute-stage ALU for the prco core.
- Sits between the decoder and the register-file/RAM write-back stage.
- Generalises data width and immediate widths, and adds SUB, logic, shift, CMP and a condition-flag register.
- Adds an optional iterative multi-cycle MUL with a busy handshake.
- Keeps the single-cycle q_ce_reg / q_ce_ram completion-pulse protocol for downstream stages.

Parameters:
- DATA_W, 16, operand/result width (≥8).
- IMM_W, 8, MOVI immediate width (≤DATA_W).
- SIMM_W, 5, signed LW/SW offset width (<DATA_W).
- MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL behaves as unknown op.

Ports:
- i_clk  in  1  core clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_ce  in  1  issue strobe from decoder, one op per high cycle
- i_dec_req_ram  in  1  op result targets RAM (1) or register file (0)
- i_op  in  5  opcode, PRCO_OP_* encoding
- i_data  in  DATA_W  operand A (signed)
- i_datb  in  DATA_W  operand B (signed)
- i_imm  in  IMM_W  MOVI immediate
- i_simm  in  SIMM_W  signed address offset
- q_result  out  DATA_W  registered result
- q_flags  out  4  {N,Z,C,V} condition flags
- q_ce_reg  out  1  one-cycle pulse: q_result valid for register write-back
- q_ce_ram  out  1  one-cycle pulse: q_result valid as RAM address
- q_busy  out  1  multi-cycle op in progress; decoder must hold issue

Behaviour:
- Reset (i_rst_n=0 at edge): q_result=0, q_flags=0, q_ce_reg=0, q_ce_ram=0, q_busy=0, state=IDLE. Reset overrides i_ce in the same cycle.
- FSM states: IDLE, MUL, DONE.
  - IDLE/DONE + i_ce + single-cycle op: result is registered at the next edge; the pulse is high exactly that one cycle.
  - IDLE/DONE + i_ce + MUL (MUL_EN=1): go to MUL.
  - MUL lasts DATA_W cycles, then DONE; DONE lasts one cycle and returns to IDLE unless a new i_ce arrives.
- Latency: single-cycle ops take 1 cycle; MUL issued at t pulses at t+DATA_W+1.
- Pulse select: i_dec_req_ram is captured at issue (held for MUL). 1 pulses q_ce_ram only; 0 pulses q_ce_reg only. Both are never high together.
- Ops (DATA_W arithmetic; wrap modulo 2^DATA_W):
  - ADD: A+B. C = carry out; V = signed overflow.
  - SUB: A−B. C = no-borrow (A≥B unsigned); V = signed overflow.
  - CMP: computes A−B and sets flags as SUB. q_result is unchanged; no pulse.
  - AND/OR/XOR: bitwise. C=V=0.
  - SHL/SHR/ASR: shift A by B[clog2(DATA_W)-1:0]; ASR sign-fills. C = last bit shifted out (0 if amount 0); V=0.
  - MOV: B. MOVI: zero-extended i_imm. LW/SW: A + sign-extended i_simm.
  - MUL: low DATA_W bits of unsigned A×B, one shift-add step per cycle. Operands are latched at issue.
  - NOP: result 0, pulse per i_dec_req_ram. Unknown op (and MUL with MUL_EN=0): result 0, pulse.
- Flags: updated only by ADD/SUB/CMP/AND/OR/XOR/shifts (N = result MSB, Z = result==0). They are held for all other ops, including MUL.
- q_busy: high from the cycle after MUL issue until the cycle the MUL pulse is asserted; it is low in that pulse cycle.
- i_ce while q_busy=1 is ignored: no state change, and inputs are not captured.
- Back-to-back: i_ce in a pulse cycle is accepted, giving consecutive pulses.
- Reset during MUL aborts the op: no pulse, q_busy=0 next cycle.

Decomposition:
- New opcodes go in the shared ISA include: PRCO_OP_SUB, AND, OR, XOR, SHL, SHR, ASR, CMP, MUL.
- Flag bit indices (FLAG_N=3 … FLAG_V=0) and FSM state encodings go in the shared constants include.
- One sub-module: prco_mul_iter. Shift-add multiplier with start/done, DATA_W parameter.

Test Plan:
- i_rst_n=0 for 2 cycles with i_ce=1, op=ADD -> all outputs 0. Release -> q_busy=0, no pulse.
- ADD 0x7FFF+0x0001, ram=0 -> next cycle q_result=0x8000, flags N=1 Z=0 C=0 V=1, q_ce_reg high 1 cycle.
- SUB 5−5 -> q_result=0, Z=1 C=1. Then CMP 3,5 -> N=1 C=0, q_result stays 0, no pulse.
- LW A=0x0100, simm=5'b11110, ram=1 -> q_result=0x00FE, q_ce_ram pulse, q_ce_reg=0, flags unchanged.
- MUL 0x0012×0x0034 at t -> q_busy t+1..t+16. Pulse and q_result=0x03A8 at t+17. i_ce ADD at t+5 ignored.
- ADD then MOVI 0xFF back-to-back -> q_ce_reg high two consecutive cycles, final q_result=0x00FF. Separately, reset at MUL t+8 -> no pulse, q_busy=0.

Source files
------------

// File: rtl/prco_alu_pipe_pkg.sv
// Shared ISA opcodes, condition-flag bit positions and FSM state encoding
// for the prco execute-stage ALU.
package prco_alu_pipe_pkg;

  localparam logic [4:0] PRCO_OP_NOP  = 5'd0;
  localparam logic [4:0] PRCO_OP_MOV  = 5'd1;
  localparam logic [4:0] PRCO_OP_MOVI = 5'd2;
  localparam logic [4:0] PRCO_OP_ADD  = 5'd3;
  localparam logic [4:0] PRCO_OP_LW   = 5'd4;
  localparam logic [4:0] PRCO_OP_SW   = 5'd5;
  localparam logic [4:0] PRCO_OP_SUB  = 5'd6;
  localparam logic [4:0] PRCO_OP_AND  = 5'd7;
  localparam logic [4:0] PRCO_OP_OR   = 5'd8;
  localparam logic [4:0] PRCO_OP_XOR  = 5'd9;
  localparam logic [4:0] PRCO_OP_SHL  = 5'd10;
  localparam logic [4:0] PRCO_OP_SHR  = 5'd11;
  localparam logic [4:0] PRCO_OP_ASR  = 5'd12;
  localparam logic [4:0] PRCO_OP_CMP  = 5'd13;
  localparam logic [4:0] PRCO_OP_MUL  = 5'd14;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/prco_alu_pipe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W
// bits kept. done flags the final step; product is valid in that same cycle.
module prco_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_step;
  logic [CNT_W-1:0]  cnt;

  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(DATA_W);
    end else if (cnt != '0) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  // Last step is folded combinationally so the owner can register it at terminal count.
  assign done    = (cnt == CNT_W'(1));
  assign product = acc_step;

endmodule

// File: rtl/prco_alu_pipe.sv
// prco execute-stage ALU: single-cycle ops plus optional iterative MUL,
// registered result/flags and one-cycle write-back pulses.
//   state | meaning
//   IDLE  | no op in flight, accepting issue
//   MUL   | multiplier iterating, issue ignored, q_busy high
//   DONE  | MUL result pulse cycle, accepting issue
module prco_alu_pipe
  import prco_alu_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int SIMM_W = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_dec_req_ram,
  input  logic [4:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_datb,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [SIMM_W-1:0] i_simm,
  output logic [DATA_W-1:0] q_result,
  output logic [3:0]        q_flags,
  output logic              q_ce_reg,
  output logic              q_ce_ram,
  output logic              q_busy
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  alu_state_e        state, state_nxt;
  logic              ram_sel, ram_sel_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic [3:0]        flags_nxt;
  logic              ce_reg_nxt, ce_ram_nxt;
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_setf, alu_wr;
  logic [DATA_W:0]   sum, diff, shl_w, shr_w, asr_w;
  logic [SH_W-1:0]   sh_amt;

  // Shifts carry one spare bit so the last bit shifted out lands in a fixed position.
  assign sh_amt = i_datb[SH_W-1:0];
  assign sum    = {1'b0, i_data} + {1'b0, i_datb};
  assign diff   = {1'b0, i_data} - {1'b0, i_datb};
  assign shl_w  = {1'b0, i_data} << sh_amt;
  assign shr_w  = {i_data, 1'b0} >> sh_amt;
  assign asr_w  = $signed({i_data, 1'b0}) >>> sh_amt;

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_setf = 1'b0;
    alu_wr   = 1'b1;
    case (i_op)
      PRCO_OP_ADD: begin
        alu_res  = sum[MSB:0];
        alu_c    = sum[DATA_W];
        alu_v    = (i_data[MSB] == i_datb[MSB]) && (sum[MSB] != i_data[MSB]);
        alu_setf = 1'b1;
      end
      PRCO_OP_SUB, PRCO_OP_CMP: begin
        alu_res  = diff[MSB:0];
        alu_c    = ~diff[DATA_W];
        alu_v    = (i_data[MSB] != i_datb[MSB]) && (diff[MSB] != i_data[MSB]);
        alu_setf = 1'b1;
        alu_wr   = (i_op != PRCO_OP_CMP);
      end
      PRCO_OP_AND: begin alu_res = i_data & i_datb; alu_setf = 1'b1; end
      PRCO_OP_OR:  begin alu_res = i_data | i_datb; alu_setf = 1'b1; end
      PRCO_OP_XOR: begin alu_res = i_data ^ i_datb; alu_setf = 1'b1; end
      PRCO_OP_SHL: begin alu_res = shl_w[MSB:0];    alu_c = shl_w[DATA_W]; alu_setf = 1'b1; end
      PRCO_OP_SHR: begin alu_res = shr_w[DATA_W:1]; alu_c = shr_w[0];      alu_setf = 1'b1; end
      PRCO_OP_ASR: begin alu_res = asr_w[DATA_W:1]; alu_c = asr_w[0];      alu_setf = 1'b1; end
      PRCO_OP_MOV:  alu_res = i_datb;
      PRCO_OP_MOVI: alu_res = DATA_W'(i_imm);
      PRCO_OP_LW, PRCO_OP_SW: alu_res = i_data + DATA_W'($signed(i_simm));
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    result_nxt  = q_result;
    flags_nxt   = q_flags;
    ce_reg_nxt  = 1'b0;
    ce_ram_nxt  = 1'b0;
    ram_sel_nxt = ram_sel;
    mul_start   = 1'b0;
    case (state)
      ST_MUL: begin
        if (mul_done) begin
          result_nxt = mul_product;
          ce_reg_nxt = ~ram_sel;
          ce_ram_nxt = ram_sel;
          state_nxt  = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        if (i_ce) begin
          ram_sel_nxt = i_dec_req_ram;
          if (MUL_EN && (i_op == PRCO_OP_MUL)) begin
            mul_start = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            if (alu_wr) begin
              result_nxt = alu_res;
              ce_reg_nxt = ~i_dec_req_ram;
              ce_ram_nxt = i_dec_req_ram;
            end
            if (alu_setf) begin
              flags_nxt[FLAG_N] = alu_res[MSB];
              flags_nxt[FLAG_Z] = (alu_res == '0);
              flags_nxt[FLAG_C] = alu_c;
              flags_nxt[FLAG_V] = alu_v;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      ram_sel  <= 1'b0;
      q_result <= '0;
      q_flags  <= '0;
      q_ce_reg <= 1'b0;
      q_ce_ram <= 1'b0;
    end else begin
      state    <= state_nxt;
      ram_sel  <= ram_sel_nxt;
      q_result <= result_nxt;
      q_flags  <= flags_nxt;
      q_ce_reg <= ce_reg_nxt;
      q_ce_ram <= ce_ram_nxt;
    end
  end

  assign q_busy = (state == ST_MUL);

  if (MUL_EN) begin : g_mul
    prco_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .start   (mul_start),
      .a       (i_data),
      .b       (i_datb),
      .done    (mul_done),
      .product (mul_product)
    );
  end else begin : g_no_mul
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

endmodule
